// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pkg
// Description : Shared constants and types for the DSP MAC sequencer.
//               - OPMODE encodings, in W[8:7] Z[6:4] Y[3:2] X[1:0] order.
//               - ALUMODE and INMODE constants.
//               - Operand widths.
//               - Sequencer state enum.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_pkg;

  localparam int A_W = 30;
  localparam int B_W = 18;
  localparam int P_W = 48;

  // W[8:7] Z[6:4] Y[3:2] X[1:0]
  localparam logic [8:0] OP_MUL   = 9'b00_000_01_01; // P = M
  localparam logic [8:0] OP_MUL_C = 9'b11_000_01_01; // P = C + M
  localparam logic [8:0] OP_MAC   = 9'b00_010_01_01; // P = P + M
  localparam logic [8:0] OP_HOLD  = 9'b00_010_00_00; // P = P + 0

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [4:0] INMODE_AB = 5'b00000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac_sequencer
// Description : Sequences a shared DSP slice through signed dot products.
//               Accepts a vector command, streams operand pairs into the DSP,
//               selects OPMODE per element, waits out the DSP latency and
//               returns the 48-bit result on a ready/valid port.
// Macro       : DSP_MAC_BIAS_EN - adds cmd_bias; the first element is then
//               issued as C + A*B instead of A*B.
// Ports       : clk, rst (sync, active-low)
//               cmd_valid/cmd_ready/cmd_len[/cmd_bias] : vector command
//               in_valid/in_ready/in_a/in_b            : operand stream
//               res_valid/res_ready/res_data           : result
//               busy                                   : not idle
//               dsp_* outputs / dsp_p input            : DSP slice interface
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_sequencer
  import dsp_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
`ifdef DSP_MAC_BIAS_EN
  input  logic [P_W-1:0]   cmd_bias,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [P_W-1:0]   res_data,
  output logic             busy,
  output logic             dsp_enable,
  output logic             dsp_rst,
  output logic [A_W-1:0]   dsp_a,
  output logic [B_W-1:0]   dsp_b,
  output logic [P_W-1:0]   dsp_c,
  output logic [8:0]       dsp_opmode,
  output logic [3:0]       dsp_alumode,
  output logic [4:0]       dsp_inmode,
  input  logic [P_W-1:0]   dsp_p
);

`ifdef DSP_MAC_BIAS_EN
  localparam logic [8:0] OP_FIRST = OP_MUL_C;
`else
  localparam logic [8:0] OP_FIRST = OP_MUL;
`endif

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               first_q, first_d;     // set once the first element has been issued
  logic [CNT_W-1:0]   drain_q, drain_d;
  logic [P_W-1:0]     res_q, res_d;
  logic [A_W-1:0]     a_q, a_d;
  logic [B_W-1:0]     b_q, b_d;
  logic [P_W-1:0]     c_q, c_d;
  logic [8:0]         op_q, op_d;

  logic w_cmd_hs;
  logic w_in_hs;
  logic w_res_hs;

  assign w_cmd_hs = cmd_valid & cmd_ready;
  assign w_in_hs  = in_valid & in_ready;
  assign w_res_hs = res_valid & res_ready;

  assign dsp_enable  = 1'b1;
  assign dsp_rst     = ~rst;
  assign dsp_alumode = ALU_ADD;
  assign dsp_inmode  = INMODE_AB;
  assign dsp_a       = a_q;
  assign dsp_b       = b_q;
  assign dsp_c       = c_q;
  assign dsp_opmode  = op_q;
  assign res_data    = res_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
      drain_q     <= '0;
      res_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      op_q        <= OP_HOLD;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      drain_q     <= drain_d;
      res_q       <= res_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      op_q        <= op_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A zero-length vector skips RUN: its single OP_FIRST is issued here.
        if (w_cmd_hs) state_d = (cmd_len == '0) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (w_in_hs && (remaining_q == LEN_W'(1))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (w_res_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    cmd_ready   = (state_q == ST_IDLE);
    in_ready    = (state_q == ST_RUN);
    res_valid   = (state_q == ST_DONE);
    busy        = (state_q != ST_IDLE);
    remaining_d = remaining_q;
    first_d     = first_q;
    drain_d     = drain_q;
    res_d       = res_q;
    c_d         = c_q;
    // Any cycle without an issued element is a bubble: P = P + 0.
    a_d         = '0;
    b_d         = '0;
    op_d        = OP_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (w_cmd_hs) begin
          remaining_d = cmd_len;
          first_d     = 1'b0;
          drain_d     = CNT_W'(LAT);
`ifdef DSP_MAC_BIAS_EN
          c_d         = cmd_bias;
`endif
          if (cmd_len == '0) op_d = OP_FIRST;
        end
      end
      ST_RUN: begin
        if (w_in_hs) begin
          a_d         = in_a;
          b_d         = in_b;
          op_d        = first_q ? OP_MAC : OP_FIRST;
          first_d     = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
        end
      end
      ST_DRAIN: begin
        // LAT+1 drain cycles let the last element reach P before capture.
        if (drain_q == '0) res_d = dsp_p;
        else               drain_d = drain_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_mac_sequencer
// Description : Directed self-checking bench for dsp_mac_sequencer. Includes
//               a behavioural DSP slice (input/control register plus P
//               register, two cycles) fed by the sequencer's dsp_* outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_sequencer;
  import dsp_pkg::*;

  localparam int LEN_W = 16;
  localparam int LAT   = 2;
`ifdef DSP_MAC_BIAS_EN
  localparam logic [8:0] OPF = OP_MUL_C;
`else
  localparam logic [8:0] OPF = OP_MUL;
`endif

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
`ifdef DSP_MAC_BIAS_EN
  logic [47:0]      cmd_bias;
`endif
  logic             in_valid;
  logic             in_ready;
  logic [29:0]      in_a;
  logic [17:0]      in_b;
  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;
  logic             busy;
  logic             dsp_enable;
  logic             dsp_rst;
  logic [29:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [47:0]      dsp_c;
  logic [8:0]       dsp_opmode;
  logic [3:0]       dsp_alumode;
  logic [4:0]       dsp_inmode;
  logic [47:0]      dsp_p;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
`ifdef DSP_MAC_BIAS_EN
    .cmd_bias(cmd_bias),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .dsp_enable(dsp_enable), .dsp_rst(dsp_rst),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_opmode(dsp_opmode),
    .dsp_alumode(dsp_alumode), .dsp_inmode(dsp_inmode), .dsp_p(dsp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DSP slice: operands/controls registered, then P registered.
  logic signed [29:0] ar;
  logic signed [17:0] br;
  logic [47:0]        cr;
  logic [8:0]         opr;
  logic [47:0]        pr;

  function automatic logic [47:0] dsp_next(input logic signed [29:0] a,
                                           input logic signed [17:0] b,
                                           input logic [47:0] c,
                                           input logic [8:0] op,
                                           input logic [47:0] p);
    logic signed [47:0] m;
    logic [47:0] xy, z, w;
    m  = a * b;
    xy = (op[3:0] == 4'b0101) ? m : 48'd0;
    z  = (op[6:4] == 3'b010) ? p : 48'd0;
    w  = (op[8:7] == 2'b11) ? c : 48'd0;
    return xy + z + w;
  endfunction

  always @(posedge clk) begin
    if (dsp_rst) begin
      ar <= '0; br <= '0; cr <= '0; opr <= '0; pr <= '0;
    end else if (dsp_enable) begin
      ar  <= dsp_a;
      br  <= dsp_b;
      cr  <= dsp_c;
      opr <= dsp_opmode;
      pr  <= dsp_next(ar, br, cr, opr, pr);
    end
  end
  assign dsp_p = pr;

  int cyc = 0;
  int ir_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_ready === 1'b1) ir_cnt <= ir_cnt + 1;
  end

  int n_pass  = 0;
  int n_total = 0;
  logic [47:0] cur_bias;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [47:0] wb(input logic [47:0] b);
`ifdef DSP_MAC_BIAS_EN
    return b;
`else
    return (b & 48'd0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int len, input logic [47:0] bias);
    int k;
    cur_bias  = bias;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
`ifdef DSP_MAC_BIAS_EN
    cmd_bias  = bias;
`endif
    k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin tick(); k++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_elem(input logic [29:0] a, input logic [17:0] b, output int t);
    int k;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin tick(); k++; end
    tick();
    t        = cyc;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic wait_valid(output int tv);
    int k;
    k = 0;
    while (res_valid !== 1'b1 && k < 100) begin tick(); k++; end
    tv = cyc;
    chk("res_valid_wait", 64'(res_valid), 64'd1);
  endtask

  task automatic get_result(input string tag, input logic [47:0] exp, output int tv);
    wait_valid(tv);
    chk(tag, 64'(res_data), 64'(exp));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_idle"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_data"},  64'(res_data),  64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_dsp_a"},     64'(dsp_a),     64'd0);
    chk({tag, "_dsp_b"},     64'(dsp_b),     64'd0);
    chk({tag, "_dsp_c"},     64'(dsp_c),     64'd0);
    chk({tag, "_opmode"},    64'(dsp_opmode), 64'(OP_HOLD));
    chk({tag, "_dsp_rst"},   64'(dsp_rst),   64'd1);
  endtask

  initial begin
    int t, tv, ir0;
    logic [47:0] e, held;
    rst = 1'b0; cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0; cur_bias = '0;
`ifdef DSP_MAC_BIAS_EN
    cmd_bias = '0;
`endif
    tick(); tick(); tick();

    // Reset state
    chk_reset_vals("rst");
    chk("rst_alumode", 64'(dsp_alumode), 64'd0);
    chk("rst_inmode",  64'(dsp_inmode),  64'd0);
    chk("rst_enable",  64'(dsp_enable),  64'd1);
    rst = 1'b1;
    tick();
    chk("run_dsp_rst", 64'(dsp_rst), 64'd0);

    // len=3, (1,4)(2,5)(3,6), bias 10: 32 + bias, no stalls
    send_cmd(3, 48'd10);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    chk("t1_dsp_c", 64'(dsp_c), 64'(wb(48'd10)));
    send_elem(30'd1, 18'd4, t);
    chk("t1_op_first", 64'(dsp_opmode), 64'(OPF));
    chk("t1_dsp_a", 64'(dsp_a), 64'd1);
    chk("t1_dsp_b", 64'(dsp_b), 64'd4);
    send_elem(30'd2, 18'd5, t);
    chk("t1_op_mac", 64'(dsp_opmode), 64'(OP_MAC));
    send_elem(30'd3, 18'd6, t);
    chk("t1_drain_in_ready", 64'(in_ready), 64'd0);
    get_result("t1_result", 48'd32 + wb(cur_bias), tv);
    // Valid from cycle t+4, i.e. the cycle starting at edge t+3.
    chk("t1_latency", 64'(tv - t), 64'd3);

    // Same vector with two-cycle gaps between elements
    send_cmd(3, 48'd10);
    send_elem(30'd1, 18'd4, t);
    tick();
    chk("t2_gap1_hold", 64'(dsp_opmode), 64'(OP_HOLD));
    chk("t2_gap1_a", 64'(dsp_a), 64'd0);
    tick();
    chk("t2_gap2_hold", 64'(dsp_opmode), 64'(OP_HOLD));
    send_elem(30'd2, 18'd5, t);
    chk("t2_op_mac", 64'(dsp_opmode), 64'(OP_MAC));
    tick();
    chk("t2_gap3_hold", 64'(dsp_opmode), 64'(OP_HOLD));
    tick();
    send_elem(30'd3, 18'd6, t);
    get_result("t2_result", 48'd32 + wb(cur_bias), tv);

    // len=0, bias -7: result is bias alone, in_ready never asserted
    ir0 = ir_cnt;
    e = -48'sd7;
    send_cmd(0, e);
    chk("t3_op_first", 64'(dsp_opmode), 64'(OPF));
    chk("t3_dsp_a", 64'(dsp_a), 64'd0);
    get_result("t3_result", wb(e), tv);
    chk("t3_no_in_ready", 64'(ir_cnt - ir0), 64'd0);

    // Sign handling: -5*3 + 536870911*(-131072) = -70368744046607
    send_cmd(2, 48'd0);
    send_elem(30'h3FFF_FFFB, 18'd3, t);
    send_elem(30'h1FFF_FFFF, 18'h20000, t);
    e = -48'sd70368744046607;
    get_result("t4_result", e, tv);

    // res_ready held low for 5 cycles: 7*(-3) = -21
    send_cmd(1, 48'd0);
    send_elem(30'd7, 18'h3FFFD, t);
    wait_valid(tv);
    held = res_data;
    e = -48'sd21;
    chk("t5_result", 64'(held), 64'(e));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_stable", 64'(res_data), 64'(held));
      chk("t5_cmd_ready_low", 64'(cmd_ready), 64'd0);
    end
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(1);
    cur_bias  = 48'd5;
`ifdef DSP_MAC_BIAS_EN
    cmd_bias  = 48'd5;
`endif
    tick();
    res_ready = 1'b0;
    chk("t5_idle_after_hs", 64'(cmd_ready), 64'd1);
    chk("t5_not_busy", 64'(busy), 64'd0);
    tick();
    cmd_valid = 1'b0;
    chk("t5_next_cmd_taken", 64'(busy), 64'd1);
    send_elem(30'd2, 18'd3, t);
    get_result("t5_next_result", 48'd6 + wb(cur_bias), tv);

    // Reset after 2 of 4 elements, then a fresh len=1 vector
    send_cmd(4, 48'd10);
    send_elem(30'd1, 18'd1, t);
    send_elem(30'd2, 18'd2, t);
    rst = 1'b0;
    tick();
    chk_reset_vals("t6");
    rst = 1'b1;
    tick();
    send_cmd(1, 48'd4);
    send_elem(30'd2, 18'd3, t);
    get_result("t6_result", 48'd6 + wb(cur_bias), tv);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
